servo_pulse_decoder: RTL and testbench

Receive-side counterpart of the servo position path: measures the high time of an incoming RC-servo pulse train and converts it into the same 16-bit position word that `servo_speed_control` consumes and produces. It sits between an external pulse source (RC receiver or a loop-back from our own PWM output) and the position/speed logic. Every good pulse yields a one-cycle `pos_valid` strobe. Malformed pulses and loss of signal are flagged separately.

---
 rtl/servo_pkg.sv | 33 +++
 rtl/sync_edge_detect.sv | 37 +++
 rtl/servo_pulse_decoder.sv | 163 ++++++++++++++++
 tb/tb_servo_pulse_decoder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared constants and types for the servo position path.
// The position width is common to servo_speed_control and servo_pulse_decoder.
package servo_pkg;

  localparam int unsigned PosWidth = 16;

  localparam int unsigned DefTickDiv    = 20;
  localparam int unsigned DefMinUs      = 1000;
  localparam int unsigned DefMaxUs      = 2000;
  localparam int unsigned DefMinValidUs = 500;
  localparam int unsigned DefMaxValidUs = 2500;
  localparam int unsigned DefTimeoutUs  = 25000;

  typedef enum logic [1:0] {
    StWaitLow,
    StArmed,
    StMeasure
  } state_e;

  // Clamp is applied before subtracting lo, so the result never wraps.
  function automatic logic [PosWidth-1:0] clamp_offset(input logic [PosWidth-1:0] w,
                                                       input logic [PosWidth-1:0] lo,
                                                       input logic [PosWidth-1:0] hi);
    if (w < lo) begin
      return '0;
    end else if (w > hi) begin
      return hi - lo;
    end else begin
      return w - lo;
    end
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous input, followed by registered
// rise/fall strobes. level is aligned with the strobes (3 clk after the input).
module sync_edge_detect #(
  parameter bit ResetLevel = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0] sync_q;
  logic       level_q;
  logic       rise_q;
  logic       fall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= {2{ResetLevel}};
      level_q <= ResetLevel;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], async_in};
      level_q <= sync_q[1];
      rise_q  <= sync_q[1] & ~level_q;
      fall_q  <= ~sync_q[1] & level_q;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/servo_pulse_decoder.sv
// Measures RC-servo pulse high time in microseconds and converts it to a
// position word; flags malformed pulses and loss of signal.
module servo_pulse_decoder
  import servo_pkg::*;
#(
  parameter int unsigned TICK_DIV     = DefTickDiv,
  parameter int unsigned MIN_US       = DefMinUs,
  parameter int unsigned MAX_US       = DefMaxUs,
  parameter int unsigned MIN_VALID_US = DefMinValidUs,
  parameter int unsigned MAX_VALID_US = DefMaxValidUs,
  parameter int unsigned TIMEOUT_US   = DefTimeoutUs
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pulse_in,
  output logic [PosWidth-1:0] pos,
  output logic                pos_valid,
  output logic                pos_error,
  output logic                signal_lost
);

  localparam int unsigned PrescW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PrescW-1:0]   PrescLast = PrescW'(TICK_DIV - 1);
  localparam logic [PosWidth-1:0] MinUs     = PosWidth'(MIN_US);
  localparam logic [PosWidth-1:0] MaxUs     = PosWidth'(MAX_US);
  localparam logic [PosWidth-1:0] MinValid  = PosWidth'(MIN_VALID_US);
  localparam logic [PosWidth-1:0] MaxValid  = PosWidth'(MAX_VALID_US);
  localparam logic [PosWidth-1:0] WidthSat  = PosWidth'(MAX_VALID_US + 1);
  localparam logic [PosWidth-1:0] Timeout   = PosWidth'(TIMEOUT_US);

  logic level;
  logic rise;
  logic fall;

  // Sync flops reset high so a pulse already in progress at reset release
  // never produces a rise, and the FSM holds in StWaitLow until it ends.
  sync_edge_detect #(
    .ResetLevel(1'b1)
  ) u_sync_edge_detect (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_in(pulse_in),
    .level   (level),
    .rise    (rise),
    .fall    (fall)
  );

  logic [PrescW-1:0]   presc_q, presc_d;
  logic                tick;
  state_e              state_q, state_d;
  logic [PosWidth-1:0] width_q, width_d;
  logic [PosWidth-1:0] width_now;
  logic [PosWidth-1:0] idle_q, idle_d;
  logic [PosWidth-1:0] pos_q, pos_d;
  logic                pos_valid_q, pos_valid_d;
  logic                pos_error_q, pos_error_d;
  logic                lost_q, lost_d;

  assign tick = (presc_q == PrescLast);

  always_comb begin
    presc_d = presc_q + 1'b1;
    if (rise || tick) begin
      presc_d = '0;
    end
  end

  // Width including a tick landing in the current cycle, so a fall in the
  // same cycle as a tick sees the full floor(high_cycles / TICK_DIV).
  always_comb begin
    width_now = width_q;
    if (tick && (width_q != WidthSat)) begin
      width_now = width_q + 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    width_d     = width_q;
    pos_d       = pos_q;
    pos_valid_d = 1'b0;
    pos_error_d = 1'b0;

    case (state_q)
      StWaitLow: begin
        if (!level) begin
          state_d = StArmed;
        end
      end
      StArmed: begin
        if (rise) begin
          state_d = StMeasure;
          width_d = '0;
        end
      end
      StMeasure: begin
        width_d = width_now;
        if (fall) begin
          state_d = StArmed;
          if ((width_now < MinValid) || (width_now > MaxValid)) begin
            pos_error_d = 1'b1;
          end else begin
            pos_valid_d = 1'b1;
            pos_d       = clamp_offset(width_now, MinUs, MaxUs);
          end
        end else if (width_now > MaxValid) begin
          // Overlong: report now, then ignore the rest of this pulse.
          pos_error_d = 1'b1;
          state_d     = StWaitLow;
        end
      end
      default: begin
        state_d = StWaitLow;
      end
    endcase
  end

  always_comb begin
    idle_d = idle_q;
    if (pos_valid_d) begin
      idle_d = '0;
    end else if (tick && (idle_q != Timeout)) begin
      idle_d = idle_q + 1'b1;
    end
  end

  // Lost is held from reset until the first good pulse arrives.
  always_comb begin
    lost_d = lost_q | (idle_d == Timeout);
    if (pos_valid_d) begin
      lost_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q     <= '0;
      state_q     <= StWaitLow;
      width_q     <= '0;
      idle_q      <= '0;
      pos_q       <= '0;
      pos_valid_q <= 1'b0;
      pos_error_q <= 1'b0;
      lost_q      <= 1'b1;
    end else begin
      presc_q     <= presc_d;
      state_q     <= state_d;
      width_q     <= width_d;
      idle_q      <= idle_d;
      pos_q       <= pos_d;
      pos_valid_q <= pos_valid_d;
      pos_error_q <= pos_error_d;
      lost_q      <= lost_d;
    end
  end

  assign pos         = pos_q;
  assign pos_valid   = pos_valid_q;
  assign pos_error   = pos_error_q;
  assign signal_lost = lost_q;

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Bench for servo_pulse_decoder: table of pulse widths plus hand-written
// sequences for overlong pulses, timeout and reset mid-pulse.
module tb_servo_pulse_decoder;

  // Microsecond limits are scaled down 20x from the defaults to keep run time
  // short; TICK_DIV stays at 20 (50 ns clock, 1 us tick).
  localparam int unsigned TickDiv    = 20;
  localparam int unsigned MinUs      = 50;
  localparam int unsigned MaxUs      = 100;
  localparam int unsigned MinValidUs = 25;
  localparam int unsigned MaxValidUs = 125;
  localparam int unsigned TimeoutUs  = 1250;
  localparam int unsigned GapCycles  = 400;
  localparam int unsigned NumVecs    = 12;

  logic        clk;
  logic        rst_n;
  logic        pulse_in;
  logic [15:0] pos;
  logic        pos_valid;
  logic        pos_error;
  logic        signal_lost;

  servo_pulse_decoder #(
    .TICK_DIV    (TickDiv),
    .MIN_US      (MinUs),
    .MAX_US      (MaxUs),
    .MIN_VALID_US(MinValidUs),
    .MAX_VALID_US(MaxValidUs),
    .TIMEOUT_US  (TimeoutUs)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pulse_in   (pulse_in),
    .pos        (pos),
    .pos_valid  (pos_valid),
    .pos_error  (pos_error),
    .signal_lost(signal_lost)
  );

  initial clk = 1'b0;
  always #25ns clk = ~clk;

  typedef struct packed {
    logic        is_err;
    logic [15:0] pos;
  } exp_t;

  typedef struct {
    int unsigned high_cycles;
    logic        exp_err;
    logic [15:0] exp_pos;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[NumVecs];
  int   n_cmp;
  int   n_bad;
  int   n_strobes;

  task automatic check(input bit ok, input string name, input int act, input int req);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  // Scoreboard: every strobe is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && (pos_valid || pos_error)) begin
      exp_t e;
      n_strobes++;
      check(!(pos_valid && pos_error), "strobe_exclusive", 32'(pos_error), 0);
      if (exp_q.size() == 0) begin
        check(1'b0, "unexpected_strobe", 32'(pos_error), -1);
      end else begin
        e = exp_q.pop_front();
        check(pos_error == e.is_err, "strobe_kind_err", 32'(pos_error), 32'(e.is_err));
        check(pos == e.pos, "strobe_pos", 32'(pos), 32'(e.pos));
      end
    end
  end

  task automatic drive_pulse(input int unsigned high_cycles);
    @(negedge clk);
    pulse_in = 1'b1;
    repeat (high_cycles) @(negedge clk);
    pulse_in = 1'b0;
  endtask

  task automatic push_exp(input logic is_err, input logic [15:0] p);
    exp_t e;
    e.is_err = is_err;
    e.pos    = p;
    exp_q.push_back(e);
  endtask

  task automatic wait_strobe(input int max_cycles, output int n, output bit seen);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(pos_valid || pos_error) && (n < max_cycles));
    seen = pos_valid || pos_error;
  endtask

  task automatic gap_and_drain(input string name);
    repeat (GapCycles) @(negedge clk);
    check(exp_q.size() == 0, name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #10ms;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  seen;
    bit  lost_before;
    int  strobes_before;

    n_cmp     = 0;
    n_bad     = 0;
    n_strobes = 0;

    vecs[0]  = '{1500, 1'b0, 16'd25};  // 75 us
    vecs[1]  = '{800,  1'b0, 16'd0};   // 40 us clamps low
    vecs[2]  = '{2300, 1'b0, 16'd50};  // 115 us clamps high
    vecs[3]  = '{1021, 1'b0, 16'd1};   // 51 us
    vecs[4]  = '{200,  1'b1, 16'd1};   // 10 us glitch, pos held
    vecs[5]  = '{1219, 1'b0, 16'd10};  // floor(60.95) = 60 us
    vecs[6]  = '{999,  1'b0, 16'd0};   // 49 us clamps low
    vecs[7]  = '{499,  1'b1, 16'd0};   // 24 us, just under min valid
    vecs[8]  = '{500,  1'b0, 16'd0};   // 25 us, exactly min valid
    vecs[9]  = '{2000, 1'b0, 16'd50};  // 100 us
    vecs[10] = '{2519, 1'b0, 16'd50};  // 125 us, exactly max valid
    vecs[11] = '{2520, 1'b1, 16'd50};  // 126 us, overlong at the fall

    rst_n    = 1'b0;
    pulse_in = 1'b0;
    repeat (5) @(negedge clk);
    check(pos == 16'd0, "reset_pos", 32'(pos), 0);
    check(pos_valid == 1'b0, "reset_pos_valid", 32'(pos_valid), 0);
    check(pos_error == 1'b0, "reset_pos_error", 32'(pos_error), 0);
    check(signal_lost == 1'b1, "reset_signal_lost", 32'(signal_lost), 1);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Good pulse: latency from the falling input edge and loss clear.
    drive_pulse(1500);
    push_exp(1'b0, 16'd25);
    wait_strobe(20, n, seen);
    check(seen && pos_valid, "good_pulse_seen", 32'(pos_valid), 1);
    check(n == 4, "fall_to_strobe_latency", n, 4);
    check(signal_lost == 1'b0, "good_pulse_lost_clear", 32'(signal_lost), 0);
    gap_and_drain("good_pulse_drain");

    for (int i = 0; i < NumVecs; i++) begin
      drive_pulse(vecs[i].high_cycles);
      push_exp(vecs[i].exp_err, vecs[i].exp_pos);
      gap_and_drain($sformatf("vec%0d_drain", i));
    end

    // Stuck high: one error, (MAX_VALID_US+1) us of ticks after the rise.
    push_exp(1'b1, 16'd50);
    @(negedge clk);
    pulse_in = 1'b1;
    wait_strobe(4000, n, seen);
    check(seen && pos_error, "stuck_error_seen", 32'(pos_error), 1);
    check(n == 3 + (MaxValidUs + 1) * TickDiv + 1, "stuck_error_latency", n,
          3 + (MaxValidUs + 1) * TickDiv + 1);
    repeat (4000 - n) @(negedge clk);
    pulse_in = 1'b0;
    gap_and_drain("stuck_drain");
    drive_pulse(1200);
    push_exp(1'b0, 16'd10);
    gap_and_drain("after_stuck_drain");

    // Timeout after the last good pulse, then same-cycle clear.
    drive_pulse(1500);
    push_exp(1'b0, 16'd25);
    wait_strobe(20, n, seen);
    check(seen && pos_valid, "timeout_ref_seen", 32'(pos_valid), 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!signal_lost && (n < TimeoutUs * TickDiv + 100));
    check(signal_lost == 1'b1, "timeout_lost_set", 32'(signal_lost), 1);
    check((n >= TimeoutUs * TickDiv - TickDiv + 1) && (n <= TimeoutUs * TickDiv),
          "timeout_latency", n, TimeoutUs * TickDiv);
    repeat (200) @(negedge clk);
    drive_pulse(1500);
    push_exp(1'b0, 16'd25);
    lost_before = signal_lost;
    n = 0;
    while (!pos_valid && (n < 20)) begin
      lost_before = signal_lost;
      @(negedge clk);
      n++;
    end
    check(pos_valid == 1'b1, "recover_seen", 32'(pos_valid), 1);
    check(lost_before == 1'b1, "recover_lost_before", 32'(lost_before), 1);
    check(signal_lost == 1'b0, "recover_lost_same_cycle", 32'(signal_lost), 0);
    gap_and_drain("recover_drain");

    // Reset 25 us into a 75 us pulse, released while the line is high.
    strobes_before = n_strobes;
    @(negedge clk);
    pulse_in = 1'b1;
    repeat (500) @(negedge clk);
    rst_n = 1'b0;
    #1ns;
    check(pos == 16'd0, "midreset_pos", 32'(pos), 0);
    check(signal_lost == 1'b1, "midreset_lost", 32'(signal_lost), 1);
    check(!pos_valid && !pos_error, "midreset_strobes", 32'(pos_valid | pos_error), 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (995) @(negedge clk);
    pulse_in = 1'b0;
    repeat (GapCycles) @(negedge clk);
    check(n_strobes == strobes_before, "midreset_no_strobe", n_strobes - strobes_before, 0);
    drive_pulse(1700);
    push_exp(1'b0, 16'd35);
    gap_and_drain("after_reset_drain");
    check(signal_lost == 1'b0, "after_reset_lost", 32'(signal_lost), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
